// File: rtl/i2c_touch_target_if.sv
// I2C pin bundle between the touch-controller emulator and its pad/bench.
// scl_in/sda_in are raw pin levels; sda_oe=1 pulls SDA low (open drain).
interface i2c_touch_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_touch_target.sv
// I2C target emulating the touch controller: address/pointer/data decode,
// a fabric-loaded register file served on reads, and the active-low touch interrupt.
module i2c_touch_target #(
  parameter logic [6:0]  DEV_ADDR   = 7'h38,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned STATUS_REG = 2
) (
  input  logic              clk,
  input  logic              rst,
  i2c_touch_target_if.slave bus,
  output logic              touch_n,
  input  logic              touch_event,
  input  logic              reg_wr_en,
  input  logic [REG_AW-1:0] reg_wr_addr,
  input  logic [7:0]        reg_wr_data,
  output logic              rx_valid,
  output logic [REG_AW-1:0] rx_addr,
  output logic [7:0]        rx_data,
  output logic              busy
);
  localparam int unsigned Depth = 2 ** REG_AW;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWrData, StDataAck, StRdData, StRdAck, StIgnore
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        scl_q, sda_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [REG_AW-1:0] ptr_q, ptr_d, rx_addr_q, rx_addr_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rw_q, rw_d, pend_q, pend_d, oe_q, oe_d;
  logic              busy_q, busy_d, rx_valid_q, rx_valid_d, touch_q;
  logic [7:0]        regs_q [Depth];
  logic              bus_we, release_touch;
  logic              scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]        rx_byte, rd_byte;

  // [0],[1] synchronizer, [2] edge history
  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_q[2];
  assign scl_fall = ~scl_s & scl_q[2];
  assign start_ev = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
  assign stop_ev  = scl_s & scl_q[2] & ~sda_q[2] & sda_s;
  assign rx_byte  = {sr_q[6:0], sda_s};
  assign rd_byte  = regs_q[ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], bus.scl_in};
      sda_q <= {sda_q[1:0], bus.sda_in};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    ptr_d         = ptr_q;
    rw_d          = rw_q;
    pend_d        = pend_q;
    oe_d          = oe_q;
    busy_d        = busy_q;
    rx_valid_d    = 1'b0;
    rx_addr_d     = rx_addr_q;
    rx_data_d     = rx_data_q;
    bus_we        = 1'b0;
    release_touch = 1'b0;
    if (start_ev) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
      pend_d  = 1'b0;
    end else if (stop_ev) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          sr_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = StAddrAck;
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end
        StPtr: if (scl_rise) begin
          sr_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ptr_d   = rx_byte[REG_AW-1:0];
            state_d = StPtrAck;
          end
        end
        StWrData: if (scl_rise) begin
          sr_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            bus_we     = 1'b1;
            rx_valid_d = 1'b1;
            rx_addr_d  = ptr_q;
            rx_data_d  = rx_byte;
            ptr_d      = ptr_q + REG_AW'(1);
            state_d    = StDataAck;
          end
        end
        // First fall drives ACK, second fall ends it; oe_q tells the two apart.
        StAddrAck, StPtrAck, StDataAck: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d  = 1'b0;
            cnt_d = '0;
            if (state_q != StAddrAck) begin
              state_d = StWrData;
            end else if (!rw_q) begin
              state_d = StPtr;
            end else begin
              state_d = StRdData;
              sr_d    = rd_byte;
              oe_d    = ~rd_byte[7];
            end
          end
        end
        StRdData: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (pend_q) begin
              pend_d = 1'b0;
              cnt_d  = '0;
              sr_d   = rd_byte;
              oe_d   = ~rd_byte[7];
            end else if (cnt_q == 3'd0) begin
              oe_d    = 1'b0;
              state_d = StRdAck;
            end else begin
              sr_d = {sr_q[6:0], 1'b0};
              oe_d = ~sr_q[6];
            end
          end
        end
        StRdAck: if (scl_rise) begin
          if (ptr_q == REG_AW'(STATUS_REG)) release_touch = 1'b1;
          if (!sda_s) begin
            ptr_d   = ptr_q + REG_AW'(1);
            pend_d  = 1'b1;
            state_d = StRdData;
          end else begin
            state_d = StIgnore;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sr_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      pend_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_addr_q  <= '0;
      rx_data_q  <= '0;
      touch_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      pend_q     <= pend_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_addr_q  <= rx_addr_d;
      rx_data_q  <= rx_data_d;
      if (touch_event)        touch_q <= 1'b0;
      else if (release_touch) touch_q <= 1'b1;
    end
  end

  // Local write beats a bus write to the same register in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (reg_wr_en && reg_wr_addr == REG_AW'(i))  regs_q[i] <= reg_wr_data;
        else if (bus_we && ptr_q == REG_AW'(i))       regs_q[i] <= rx_byte;
      end
    end
  end

  assign bus.sda_oe = oe_q;
  assign touch_n    = touch_q;
  assign rx_valid   = rx_valid_q;
  assign rx_addr    = rx_addr_q;
  assign rx_data    = rx_data_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_i2c_touch_target.sv
// Directed + randomized I2C master bench for i2c_touch_target against a
// transaction-level register-file/pointer/interrupt model.
module tb_i2c_touch_target;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       touch_n, touch_event = 1'b0;
  logic       reg_wr_en = 1'b0;
  logic [3:0] reg_wr_addr = '0;
  logic [7:0] reg_wr_data = '0;
  logic       rx_valid, busy;
  logic [3:0] rx_addr;
  logic [7:0] rx_data;

  i2c_touch_target_if bif ();
  assign bif.scl_in = scl_m;
  assign bif.sda_in = sda_m & ~bif.sda_oe;

  i2c_touch_target dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .touch_n     (touch_n),
    .touch_event (touch_event),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .rx_valid    (rx_valid),
    .rx_addr     (rx_addr),
    .rx_data     (rx_data),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [7:0]  m_regs [16];
  int          m_ptr = 0;
  logic        m_touch = 1'b1;
  logic [11:0] exp_rx [$];
  logic [11:0] got_rx [$];
  int          rx_chk = 0;
  int          oe_cnt = 0, busy_cnt = 0;
  logic [7:0]  wbuf [4];

  always @(negedge clk) begin
    if (rx_valid) got_rx.push_back({rx_addr, rx_data});
    if (bif.sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(2); sda_m = 1'b0; wq(2); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(2); sda_m = 1'b1; wq(2);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      wq(); sda_m = b[i]; wq(); scl_m = 1'b1; wq(2); scl_m = 1'b0;
    end
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); ack = ~bif.sda_in; wq(); scl_m = 1'b0;
  endtask

  task automatic rbyte(input logic ack_out, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b[i] = bif.sda_in; wq(); scl_m = 1'b0;
    end
    wq(); sda_m = ~ack_out; wq(); scl_m = 1'b1; wq(2); scl_m = 1'b0;
  endtask

  task automatic local_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
    @(negedge clk); reg_wr_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic pulse_touch();
    @(negedge clk); touch_event = 1'b1;
    @(negedge clk); touch_event = 1'b0;
    m_touch = 1'b0;
    check("touch_assert", touch_n, m_touch);
  endtask

  task automatic check_rx();
    check("rx_count", got_rx.size(), exp_rx.size());
    for (int i = rx_chk; i < got_rx.size() && i < exp_rx.size(); i++)
      check("rx_entry", got_rx[i], exp_rx[i]);
    rx_chk = got_rx.size();
  endtask

  task automatic tx_write(input logic [7:0] ptrb, input int n);
    logic ack;
    i2c_start();
    wbyte(8'h70, ack); check("wr_addr_ack", ack, 1);
    wbyte(ptrb, ack);  check("wr_ptr_ack", ack, 1);
    m_ptr = int'(ptrb[3:0]);
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], ack); check("wr_data_ack", ack, 1);
      m_regs[m_ptr] = wbuf[i];
      exp_rx.push_back({4'(m_ptr), wbuf[i]});
      m_ptr = (m_ptr + 1) % 16;
    end
    check("wr_busy", busy, 1);
    i2c_stop();
    check("wr_busy_stop", busy, 0);
    check_rx();
  endtask

  task automatic tx_read(input int n, input logic set_ptr, input logic [7:0] ptrb);
    logic ack;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      wbyte(8'h70, ack); check("rd_waddr_ack", ack, 1);
      wbyte(ptrb, ack);  check("rd_ptr_ack", ack, 1);
      m_ptr = int'(ptrb[3:0]);
      i2c_start();
    end
    wbyte(8'h71, ack); check("rd_addr_ack", ack, 1);
    check("rd_touch_pre", touch_n, m_touch);
    for (int i = 0; i < n; i++) begin
      rbyte((i < n - 1) ? 1'b1 : 1'b0, b);
      check("rd_data", b, m_regs[m_ptr]);
      if (m_ptr == 2) m_touch = 1'b1;
      check("rd_touch", touch_n, m_touch);
      if (i < n - 1) m_ptr = (m_ptr + 1) % 16;
    end
    i2c_stop();
    check("rd_busy_stop", busy, 0);
  endtask

  initial begin
    logic ack, hit;
    logic [7:0] b, exp_b;
    int oe0, busy0, rx0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", bif.sda_oe, 0);
    check("rst_touch_n", touch_n, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_addr", rx_addr, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);

    // Basic write then readback.
    wbuf[0] = 8'hA5;
    tx_write(8'h03, 1);
    tx_read(1, 1'b1, 8'h03);

    // Read with repeated START and interrupt release on STATUS_REG.
    local_write(4'd2, 8'h01);
    local_write(4'd3, 8'h80);
    pulse_touch();
    tx_read(2, 1'b1, 8'h02);

    // Address mismatch: no drive, no busy, no rx.
    oe0 = oe_cnt; busy0 = busy_cnt; rx0 = got_rx.size();
    i2c_start();
    wbyte(8'h72, ack); check("mm_addr_nack", ack, 0);
    wbyte(8'h00, ack); check("mm_data_nack", ack, 0);
    i2c_stop();
    check("mm_oe", oe_cnt - oe0, 0);
    check("mm_busy", busy_cnt - busy0, 0);
    check("mm_rx", got_rx.size() - rx0, 0);

    // Pointer wrap.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    tx_write(8'h0F, 2);
    tx_read(2, 1'b1, 8'h0F);

    // Snapshot: local write mid-byte must not tear the byte in flight.
    local_write(4'd9, 8'h96);
    i2c_start();
    wbyte(8'h70, ack); check("snap_waddr_ack", ack, 1);
    wbyte(8'h09, ack); check("snap_ptr_ack", ack, 1);
    m_ptr = 9;
    i2c_start();
    wbyte(8'h71, ack); check("snap_raddr_ack", ack, 1);
    exp_b = m_regs[9];
    fork
      rbyte(1'b0, b);
      begin
        repeat (3) @(posedge scl_m);
        local_write(4'd9, 8'h00);
      end
    join
    check("snap_data", b, exp_b);
    i2c_stop();
    tx_read(1, 1'b1, 8'h09);

    // Collision: local write held through the cycle the bus byte lands.
    i2c_start();
    wbyte(8'h70, ack); check("col_addr_ack", ack, 1);
    wbyte(8'h05, ack); check("col_ptr_ack", ack, 1);
    reg_wr_addr = 4'd5; reg_wr_data = 8'hC3;
    hit = 1'b0;
    fork
      wbyte(8'h3C, ack);
      begin
        repeat (7) @(posedge scl_m);
        reg_wr_en = 1'b1;
        for (int k = 0; k < 400 && !rx_valid; k++) @(negedge clk);
        hit = rx_valid;
        reg_wr_en = 1'b0;
      end
    join
    check("col_data_ack", ack, 1);
    check("col_rx_seen", hit, 1);
    m_regs[5] = 8'hC3;
    exp_rx.push_back({4'd5, 8'h3C});
    m_ptr = 6;
    i2c_stop();
    check_rx();
    tx_read(1, 1'b1, 8'h05);

    // Reset while the target is driving a 0 data bit.
    local_write(4'd4, 8'h3C);
    i2c_start();
    wbyte(8'h70, ack); check("rr_waddr_ack", ack, 1);
    wbyte(8'h04, ack); check("rr_ptr_ack", ack, 1);
    i2c_start();
    wbyte(8'h71, ack); check("rr_raddr_ack", ack, 1);
    wq();
    check("rr_driving", bif.sda_oe, 1);
    rst = 1'b0;
    #1;
    check("rr_oe_async", bif.sda_oe, 0);
    check("rr_busy", busy, 0);
    check("rr_touch_n", touch_n, 1);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_touch = 1'b1;
    repeat (4) @(negedge clk);
    local_write(4'd0, 8'h5A);
    tx_read(1, 1'b0, 8'h00);

    // Randomized traffic against the model.
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: local_write(4'($urandom_range(0, 15)), 8'($urandom));
        1: begin
          int n;
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          tx_write(8'($urandom), n);
        end
        2: tx_read($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
        default: pulse_touch();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_touch_target.md
# i2c_touch_target

I2C target (responder) that emulates the capacitive touch controller on the GPIO_1 touch header (device address 0x38) so the NIOS-side I2C master and touch driver can run against known data without a panel fitted. It decodes START/STOP, the address byte, a register-pointer byte and data bytes. It serves reads from a local register file that fabric logic loads, and it drives the active-low touch interrupt line.

## Interface
- DEV_ADDR, 7'h38: 7-bit target address answered.
- REG_AW, 4: register-pointer width; the register file holds 2^REG_AW bytes.
- STATUS_REG, 2: register whose completed read releases touch_n.
- clk  in  1  system clock (CLOCK_50); one clock domain.
- rst  in  1  reset, asynchronous, active-low.
- scl_in  in  1  SCL pin level (raw, asynchronous).
- sda_in  in  1  SDA pin level (raw, asynchronous).
- sda_oe  out  1  1 = pull SDA low; the top level ties the pad as sda_oe ? 1'b0 : 1'bz.
- touch_n  out  1  active-low interrupt to the master's touch input.
- touch_event  in  1  one-cycle pulse that asserts touch_n.
- reg_wr_en  in  1  local register-file write strobe.
- reg_wr_addr  in  REG_AW  local write address.
- reg_wr_data  in  8  local write data.
- rx_valid  out  1  one-cycle pulse when a bus-written data byte is accepted.
- rx_addr  out  REG_AW  register address of that byte.
- rx_data  out  8  the byte itself.
- busy  out  1  high from the START that addresses this target until the STOP or abort.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, followed by a 1-flop edge history. Events are derived from the synchronized signals only:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise / SCL fall: edges of synchronized SCL.
- Data is sampled on SCL rise and driven after SCL fall. Bytes are MSB first, 3-bit bit counter.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits. On a match with DEV_ADDR, go to ADDR_ACK; otherwise go to IGNORE, which waits for START/STOP without driving.
  - ADDR_ACK: drive ACK. Then R/W=0 → PTR; R/W=1 → RD_DATA.
  - PTR → PTR_ACK: pointer <= received byte[REG_AW-1:0]; upper bits are ignored.
  - PTR_ACK → WR_DATA.
  - WR_DATA → DATA_ACK: write regfile[pointer], pulse rx_valid, pointer+1.
  - DATA_ACK → WR_DATA.
  - RD_DATA → RD_ACK: after 8 bits, release SDA and sample the master's ACK on SCL rise. ACK → pointer+1 and RD_DATA. NACK → IGNORE.
- START in any state (repeated START) → ADDR with the bit counter cleared; the pointer is kept.
- STOP in any state → IDLE; the pointer is kept.
- Pointer increment wraps from 2^REG_AW−1 to 0.
- Read byte is snapshotted into the shift register on the SCL fall that begins the byte. Later local writes do not tear a byte in flight.
- Same-cycle local write and bus write to the same register: the local write wins. rx_valid still pulses with the bus byte.
- touch_n:
  - Goes low on touch_event.
  - Returns high when a read byte from STATUS_REG completes, i.e. at the master's ACK/NACK sample.
  - touch_event in the same cycle as a release: low wins.

## Timing
- Reset values:
  - sda_oe=0, touch_n=1, rx_valid=0, rx_addr=0, rx_data=0, busy=0.
  - State IDLE, pointer 0, register file all 0x00.
- Pin-to-event latency is 3 clk (2 sync + 1 edge).
- sda_oe changes exactly 1 clk after the internal SCL-fall event.
- ACK is driven (sda_oe=1) from the SCL fall after bit 8 until the next SCL fall.
- rx_valid pulses 1 clk after the SCL rise that samples bit 8 of a write byte.
- Supported SCL ≤ 400 kHz with clk = 50 MHz. SDA setup/hold is met by construction because the output changes ≥ 60 ns after SCL fall.
- Reset asserted mid-transfer: sda_oe drops to 0 asynchronously and all state returns to its reset value.
- Glitches on SCL/SDA shorter than 2 clk are not guaranteed to be filtered.

## Test plan
- Write: START, 0x70, 0x03, 0xA5, STOP.
  - ACK on all three bytes.
  - rx_valid once with rx_addr=3, rx_data=0xA5.
  - regfile[3]=0xA5; busy falls at STOP.
- Read with repeated START:
  - Local writes reg2=0x01, reg3=0x80, then touch_event.
  - Bus: START, 0x70, 0x02, repeated START, 0x71, read 2 bytes (ACK then NACK), STOP.
  - Required: data 0x01, 0x80; touch_n low until byte 1 completes, high afterwards.
- Address mismatch: START, 0x72 (addr 0x39), 0x00, STOP.
  - sda_oe stays 0 for the whole transaction; busy stays 0; no rx_valid.
- Pointer wrap: pointer 0x0F, write 0x11 then 0x22.
  - regfile[15]=0x11, regfile[0]=0x22.
  - rx_addr sequence 15, 0.
- Snapshot/collision:
  - Local write to the register being read, issued mid-byte: the bus still returns the old value.
  - Same-cycle local and bus write to register 5: regfile[5] holds the local value.
- Reset mid-read: assert rst while driving a 0 bit.
  - sda_oe=0 immediately; after release, the next START + 0x71 is served from pointer 0.
